// File: rtl/front_panel_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// front_panel_ctrl: synchronizes/debounces operator switches and generates
// startstop, sst, halt and timed cpuReset strobes for the sequencer.
// Revision: 1.0
// ---------------------------------------------------------------------------
module front_panel_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 4096,
  parameter int REPEAT_RATE     = 1024,
  parameter int RESET_CYCLES    = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic swRun,
  input  logic swStep,
  input  logic swHalt,
  input  logic swReset,
  input  logic running,
  output logic startstop,
  output logic sst,
  output logic halt,
  output logic cpuReset,
  output logic stepBusy
);

  localparam int DCW          = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int REP_MAX      = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPW          = $clog2(REP_MAX + 2);
  localparam int RSW          = $clog2(RESET_CYCLES + 1);
  localparam int STEP_TIMEOUT = 8;
  localparam int SW_RUN       = 0;
  localparam int SW_STEP      = 1;
  localparam int SW_HALT      = 2;
  localparam int SW_RESET     = 3;

  logic [3:0] raw;
  logic [3:0] sync1;
  logic [3:0] sync2;
  logic [3:0] stable;
  logic [3:0] rise_now;
  logic [3:0] rise;

  assign raw = {swReset, swHalt, swStep, swRun};

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  generate
    for (genvar i = 0; i < 4; i++) begin : g_debounce
      logic [DCW-1:0] cnt;
      logic           level;
      logic           edge_hit;
      logic           flip;

      // Flip on the edge that would take the counter to DEBOUNCE_CYCLES.
      assign flip        = (sync2[i] != level) && (cnt == DCW'(DEBOUNCE_CYCLES - 1));
      assign rise_now[i] = flip & sync2[i];
      assign stable[i]   = level;
      assign rise[i]     = edge_hit;

      always_ff @(posedge clk) begin
        if (reset) begin
          cnt      <= '0;
          level    <= 1'b0;
          edge_hit <= 1'b0;
        end else begin
          edge_hit <= rise_now[i];
          if ((sync2[i] == level) || flip) begin
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
          if (flip) begin
            level <= sync2[i];
          end
        end
      end
    end
  endgenerate

  logic [RSW-1:0] rst_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      rst_cnt <= '0;
    end else if (rise_now[SW_RESET]) begin
      rst_cnt <= RSW'(RESET_CYCLES);
    end else if (rst_cnt != '0) begin
      rst_cnt <= rst_cnt - 1'b1;
    end
  end

  assign cpuReset  = (rst_cnt != '0);
  assign halt      = stable[SW_HALT];
  assign startstop = rise[SW_RUN] & ~cpuReset;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_PULSE      = 3'd1,
    S_WAIT_START = 3'd2,
    S_WAIT_STOP  = 3'd3,
    S_HOLD       = 3'd4
  } step_state_t;

  step_state_t    state;
  step_state_t    state_nx;
  logic [2:0]     wait_cnt;
  logic [2:0]     wait_nx;
  logic [RPW-1:0] rep_cnt;
  logic [RPW-1:0] rep_nx;
  logic           repeating;
  logic           repeating_nx;
  logic           force_idle;

  // Forcing on the load edge keeps stepBusy low for the whole cpuReset window.
  assign force_idle = cpuReset | rise_now[SW_RESET];

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      rep_cnt   <= '0;
      repeating <= 1'b0;
    end else begin
      state     <= state_nx;
      wait_cnt  <= wait_nx;
      rep_cnt   <= rep_nx;
      repeating <= repeating_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    wait_nx      = wait_cnt;
    rep_nx       = rep_cnt;
    repeating_nx = repeating;
    case (state)
      S_IDLE: begin
        repeating_nx = 1'b0;
        if (rise[SW_STEP] && !rise[SW_RUN] && !running && !cpuReset) begin
          state_nx = S_PULSE;
        end
      end
      S_PULSE: begin
        state_nx = S_WAIT_START;
        wait_nx  = '0;
      end
      S_WAIT_START: begin
        if (running) begin
          state_nx = S_WAIT_STOP;
        end else if (wait_cnt == 3'(STEP_TIMEOUT - 1)) begin
          state_nx = S_IDLE;
        end else begin
          wait_nx = wait_cnt + 1'b1;
        end
      end
      S_WAIT_STOP: begin
        if (!running) begin
          if (stable[SW_STEP]) begin
            state_nx     = S_HOLD;
            rep_nx       = repeating ? RPW'(REPEAT_RATE) : RPW'(REPEAT_DELAY);
            repeating_nx = 1'b1;
          end else begin
            state_nx = S_IDLE;
          end
        end
      end
      S_HOLD: begin
        if (!stable[SW_STEP]) begin
          state_nx = S_IDLE;
        end else if (rep_cnt <= RPW'(1)) begin
          state_nx = S_PULSE;
        end else begin
          rep_nx = rep_cnt - 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
    if (force_idle) begin
      state_nx = S_IDLE;
    end
  end

  assign sst      = (state == S_PULSE) & ~cpuReset;
  assign stepBusy = (state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_front_panel_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_front_panel_ctrl: directed bench with pulse-timing scoreboard and a
// simple sequencer running model.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_front_panel_ctrl;

  localparam int D    = 4;
  localparam int RD   = 10;
  localparam int RR   = 5;
  localparam int RC   = 8;
  localparam int L    = 20;
  localparam int DLAT = D + 2;  // raw change driven at tick t -> derived pulse seen at tick t+DLAT

  logic clk = 1'b0;
  logic reset, swRun, swStep, swHalt, swReset, running;
  logic startstop, sst, halt, cpuReset, stepBusy;

  always #5 clk = ~clk;

  front_panel_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR),
    .RESET_CYCLES   (RC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .swRun    (swRun),
    .swStep   (swStep),
    .swHalt   (swHalt),
    .swReset  (swReset),
    .running  (running),
    .startstop(startstop),
    .sst      (sst),
    .halt     (halt),
    .cpuReset (cpuReset),
    .stepBusy (stepBusy)
  );

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int ss_q[$];
  int sst_q[$];
  bit model_en = 1'b0;
  int run_left = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d (tick %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: sample after the edge, score pulses, then update the running model.
  task automatic tick();
    bit exp_ss;
    bit exp_sst;
    @(posedge clk);
    #1;
    cyc++;
    exp_ss  = (ss_q.size() > 0) && (ss_q[0] == cyc);
    exp_sst = (sst_q.size() > 0) && (sst_q[0] == cyc);
    if (exp_ss) void'(ss_q.pop_front());
    if (exp_sst) void'(sst_q.pop_front());
    check("startstop", {31'd0, startstop}, {31'd0, exp_ss});
    check("sst", {31'd0, sst}, {31'd0, exp_sst});
    if (model_en) begin
      if (sst === 1'b1) begin
        running  = 1'b1;
        run_left = L;
      end else if (run_left > 0) begin
        run_left--;
        if (run_left == 0) running = 1'b0;
      end
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  initial begin
    int t, t2, s, s1, s2, s3, p;
    reset = 1'b1; swRun = 1'b0; swStep = 1'b0; swHalt = 1'b0; swReset = 1'b0; running = 1'b0;

    repeat (3) begin
      tick();
      check("reset_outputs", {27'd0, startstop, sst, halt, cpuReset, stepBusy}, 32'd0);
    end
    reset = 1'b0;
    tick();
    check("post_reset_outputs", {27'd0, startstop, sst, halt, cpuReset, stepBusy}, 32'd0);

    // Run press: single startstop after debounce latency; halt follows its switch.
    t = cyc;
    swRun = 1'b1; swHalt = 1'b1;
    ss_q.push_back(t + DLAT);
    wait_until(t + DLAT - 1);
    check("halt_before", {31'd0, halt}, 32'd0);
    tick();
    check("halt_after", {31'd0, halt}, 32'd1);
    ticks(6);
    swRun = 1'b0;
    ticks(12);

    // Bouncing step press, one instruction, release during first HOLD.
    model_en = 1'b1;
    swStep = 1'b1; tick();
    swStep = 1'b0; tick();
    swStep = 1'b1;
    t2 = cyc;
    s = t2 + DLAT + 1;
    sst_q.push_back(s);
    wait_until(s + L + 1);
    check("hold_busy", {31'd0, stepBusy}, 32'd1);
    swStep = 1'b0;
    wait_until(s + L + 7);
    check("busy_until_release", {31'd0, stepBusy}, 32'd1);
    tick();
    check("idle_after_release", {31'd0, stepBusy}, 32'd0);
    ticks(15);

    // Held step: three instructions spaced by delay then rate, release in HOLD.
    p = cyc;
    swStep = 1'b1;
    s1 = p + DLAT + 1;
    s2 = s1 + L + RD + 1;
    s3 = s2 + L + RR + 1;
    sst_q.push_back(s1);
    sst_q.push_back(s2);
    sst_q.push_back(s3);
    wait_until(s3 + L - 1);
    swStep = 1'b0;
    wait_until(s3 + L + 5);
    check("repeat_hold_busy", {31'd0, stepBusy}, 32'd1);
    tick();
    check("repeat_release_idle", {31'd0, stepBusy}, 32'd0);
    ticks(15);

    // Step ignored while running continuously.
    model_en = 1'b0;
    running = 1'b1;
    tick();
    swStep = 1'b1;
    ticks(DLAT + 4);
    check("busy_while_running", {31'd0, stepBusy}, 32'd0);
    swStep = 1'b0;
    ticks(DLAT + 2);
    running = 1'b0;
    model_en = 1'b1;
    tick();

    // Simultaneous run and step edges: startstop only.
    t = cyc;
    swRun = 1'b1; swStep = 1'b1;
    ss_q.push_back(t + DLAT);
    ticks(DLAT + 4);
    check("busy_simultaneous", {31'd0, stepBusy}, 32'd0);
    swRun = 1'b0; swStep = 1'b0;
    ticks(DLAT + 2);

    // cpuReset during WAIT_STOP, run press suppressed while it is high.
    p = cyc;
    swStep = 1'b1;
    s = p + DLAT + 1;
    sst_q.push_back(s);
    wait_until(s + 5);
    check("wait_stop_busy", {31'd0, stepBusy}, 32'd1);
    swReset = 1'b1;
    wait_until(s + 10);
    check("cpureset_before", {31'd0, cpuReset}, 32'd0);
    check("busy_before_reset", {31'd0, stepBusy}, 32'd1);
    tick();
    check("cpureset_start", {31'd0, cpuReset}, 32'd1);
    check("busy_forced_idle", {31'd0, stepBusy}, 32'd0);
    swRun = 1'b1;
    while (cyc < s + 10 + RC) begin
      tick();
      check("cpureset_held", {31'd0, cpuReset}, 32'd1);
      check("busy_in_reset", {31'd0, stepBusy}, 32'd0);
      check("halt_not_gated", {31'd0, halt}, 32'd1);
    end
    tick();
    check("cpureset_end", {31'd0, cpuReset}, 32'd0);
    swReset = 1'b0; swStep = 1'b0; swRun = 1'b0;
    ticks(DLAT + L);

    // WAIT_START timeout, then a normal step.
    model_en = 1'b0;
    running = 1'b0;
    p = cyc;
    swStep = 1'b1;
    s = p + DLAT + 1;
    sst_q.push_back(s);
    wait_until(s + 8);
    check("timeout_busy", {31'd0, stepBusy}, 32'd1);
    tick();
    check("timeout_idle", {31'd0, stepBusy}, 32'd0);
    swStep = 1'b0;
    ticks(DLAT + 2);
    model_en = 1'b1;
    p = cyc;
    swStep = 1'b1;
    s = p + DLAT + 1;
    sst_q.push_back(s);
    wait_until(s);
    swStep = 1'b0;
    wait_until(s + L);
    check("after_timeout_busy", {31'd0, stepBusy}, 32'd1);
    tick();
    check("after_timeout_idle", {31'd0, stepBusy}, 32'd0);
    ticks(10);

    check("startstop_queue_drained", ss_q.size(), 32'd0);
    check("sst_queue_drained", sst_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
